// File: rtl/aibcr3_dcc_dlyline_ctrl_if.sv
// Request/scan/decode bundle for the DCC delay-line controller.
// The master side is the requester/tester; the slave side is the controller.
interface aibcr3_dcc_dlyline_ctrl_if #(
  parameter int unsigned CRS_BITS  = 8,
  parameter int unsigned FINE_BITS = 3
);
  localparam int unsigned W = CRS_BITS + FINE_BITS;

  logic                     upd_req;
  logic [W-1:0]             tgt_code;
  logic                     slew_en;
  logic                     SE;
  logic                     SI;
  logic                     SO;
  logic                     busy;
  logic                     done;
  logic [W-1:0]             cur_code;
  logic [FINE_BITS-1:0]     gry;
  logic [2**CRS_BITS-1:0]   crs_therm;

  modport master (
    output upd_req, tgt_code, slew_en, SE, SI,
    input  SO, busy, done, cur_code, gry, crs_therm
  );

  modport slave (
    input  upd_req, tgt_code, slew_en, SE, SI,
    output SO, busy, done, cur_code, gry, crs_therm
  );
endinterface

// File: rtl/aibcr3_dcc_dlyline_ctrl.sv
// DCC coarse delay line + fine interpolator controller: slews the applied code
// toward a requested target with settle gaps, and exposes the code on a scan chain.
module aibcr3_dcc_dlyline_ctrl #(
  parameter int unsigned CRS_BITS   = 8,
  parameter int unsigned FINE_BITS  = 3,
  parameter int unsigned STEP_SIZE  = 1,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned RST_CODE   = 0
) (
  input logic CLK,
  input logic RST,
  aibcr3_dcc_dlyline_ctrl_if.slave bus
);
  localparam int unsigned W     = CRS_BITS + FINE_BITS;
  localparam int unsigned NCRS  = 2**CRS_BITS;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, STEP, SETTLE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     cur, cur_nxt;
  logic [W-1:0]     tgt_q, tgt_nxt;
  logic             mode_q, mode_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;

  logic             up;
  logic [W-1:0]     diff;
  logic [W-1:0]     delta;

  // Step magnitude is clamped to the remaining distance so a slew never overshoots.
  always_comb begin
    up    = (tgt_q > cur);
    diff  = up ? (tgt_q - cur) : (cur - tgt_q);
    delta = diff;
    if (mode_q && (32'(diff) > STEP_SIZE))
      delta = W'(STEP_SIZE);
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    tgt_nxt   = tgt_q;
    mode_nxt  = mode_q;
    cnt_nxt   = cnt;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;

    if (bus.SE) begin
      cur_nxt   = {bus.SI, cur[W-1:1]};
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.upd_req) begin
            tgt_nxt   = bus.tgt_code;
            mode_nxt  = bus.slew_en;
            state_nxt = STEP;
            busy_nxt  = 1'b1;
          end
        end
        STEP: begin
          if (cur == tgt_q) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            cur_nxt   = up ? (cur + delta) : (cur - delta);
            state_nxt = SETTLE;
            cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
          end
        end
        SETTLE: begin
          if (cnt == '0) state_nxt = STEP;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cur    <= W'(RST_CODE);
      tgt_q  <= W'(RST_CODE);
      mode_q <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cur    <= cur_nxt;
      tgt_q  <= tgt_nxt;
      mode_q <= mode_nxt;
      cnt    <= cnt_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  logic [CRS_BITS-1:0]  crs;
  logic [FINE_BITS-1:0] fine;
  logic [NCRS-1:0]      therm;

  assign crs  = cur[W-1:FINE_BITS];
  assign fine = cur[FINE_BITS-1:0];

  always_comb begin
    therm = '0;
    for (int unsigned i = 0; i < NCRS; i++)
      therm[i] = (i < 32'(crs));
  end

  assign bus.cur_code  = cur;
  assign bus.gry       = fine ^ (fine >> 1);
  assign bus.crs_therm = therm;
  assign bus.SO        = cur[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
